// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: six-digit time-multiplexed 7-seg driver with per-frame snapshots and game-over blink of the points.
// Define SEG7_SCAN_LZB_EN to blank leading zeros of the points hundreds/tens digits.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg7_level,
  input  logic [6:0] seg7_timer_1,
  input  logic [6:0] seg7_timer_0,
  input  logic [6:0] seg7_points_2,
  input  logic [6:0] seg7_points_1,
  input  logic [6:0] seg7_points_0,
  input  logic       done,
  output logic [6:0] seg_out,
  output logic [5:0] dig_sel,
  output logic       frame_tick
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] ZERO = 7'b0111111;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0] idx_q, idx_d;
  logic [5:0][6:0] snap_q, snap_d, live;
  logic dl_q, dl_d, blink_on_q, blink_on_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [6:0] seg_out_q, pat;
  logic [5:0] dig_sel_q, dig_sel_d;
  logic frame_tick_q;
  logic pre_end, wrap, blink_last, blank_blink, blank_lz;
  assign live = {seg7_points_0, seg7_points_1, seg7_points_2, seg7_timer_0, seg7_timer_1, seg7_level};
  assign seg_out = seg_out_q;
  assign dig_sel = dig_sel_q;
  assign frame_tick = frame_tick_q;
  always_comb begin
    pre_end = pre_q == PW'(SCAN_DIV - 1);
    wrap = pre_end && idx_q == 3'd5;
    pre_d = pre_end ? '0 : pre_q + PW'(1);
    idx_d = !pre_end ? idx_q : (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1);
    snap_d = wrap ? live : snap_q;
    // the latch clears once a restart has reloaded the timer tens digit away from '0'
    dl_d = done | (dl_q & (snap_q[1] == ZERO));
    blink_last = blink_cnt_q == BW'(BLINK_DIV - 1);
    blink_cnt_d = !dl_q ? '0 : !wrap ? blink_cnt_q : blink_last ? '0 : blink_cnt_q + BW'(1);
    blink_on_d = !dl_q ? 1'b1 : (wrap && blink_last) ? ~blink_on_q : blink_on_q;
    blank_blink = idx_q >= 3'd3 && dl_q && !blink_on_q;
`ifdef SEG7_SCAN_LZB_EN
    blank_lz = (idx_q == 3'd3 && snap_q[3] == ZERO) ||
               (idx_q == 3'd4 && snap_q[3] == ZERO && snap_q[4] == ZERO);
`else
    blank_lz = 1'b0;
`endif
    pat = (blank_blink || blank_lz) ? 7'd0 : snap_q[idx_q];
    dig_sel_d = 6'b000001 << idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      snap_q <= '0;
      dl_q <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q <= 1'b1;
      seg_out_q <= '0;
      dig_sel_q <= 6'b000001;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      dl_q <= dl_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q <= blink_on_d;
      seg_out_q <= pat;
      dig_sel_q <= dig_sel_d;
      frame_tick_q <= wrap;
    end
  end
endmodule
